// File: rtl/atomic_counter_reader_if.sv
// Read link between the snapshot reader (master) and the atomic counter (slave).
// The reader raises req_o/atomic_o. The counter answers with a one-cycle ack_i and count_i in the same cycle.
// Signal names are taken from the reader's side of the link.
interface atomic_counter_reader_if #(
   parameter int COUNT_W = 32
);
   logic               req_o;
   logic               atomic_o;
   logic               ack_i;
   logic [COUNT_W-1:0] count_i;

   modport master (
      output req_o,
      output atomic_o,
      input  ack_i,
      input  count_i
   );

   modport slave (
      input  req_o,
      input  atomic_o,
      output ack_i,
      output count_i
   );
endinterface

// File: rtl/atomic_counter_reader.sv
// Two-beat snapshot reader. Beat 1 is an atomic read that returns the low word and freezes the high word. Beat 2 returns the frozen high word.
// Latency: start_i to valid_o is 5 cycles when the counter acks on the first req cycle. Each beat aborts after TIMEOUT_CYCLES cycles without ack.
// Backpressure: start_i is ignored while busy. Optional feature macro ACR_DELTA_EN adds delta_o, the wrapping difference from the previous snapshot.
module atomic_counter_reader #(
   parameter int COUNT_W        = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   atomic_counter_reader_if.master bus,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic [2*COUNT_W-1:0]   value_o,
   output logic                   timeout_o
`ifdef ACR_DELTA_EN
   ,
   output logic [2*COUNT_W-1:0]   delta_o
`endif
);

   localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_LO = 3'd1,
      GAP    = 3'd2,
      REQ_HI = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [COUNT_W-1:0]   lo_q, lo_d;
   logic [COUNT_W-1:0]   hi_q, hi_d;
   logic [2*COUNT_W-1:0] value_q, value_d;
   logic                 valid_q, valid_d;
   logic                 timeout_q, timeout_d;
   logic                 req_q, req_d;
   logic                 atomic_q, atomic_d;
`ifdef ACR_DELTA_EN
   logic [2*COUNT_W-1:0] prev_q, prev_d;
   logic [2*COUNT_W-1:0] delta_q, delta_d;
`endif

   // Next-state and next-output decode; req/atomic follow the state being entered so they are registered
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      value_d   = value_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef ACR_DELTA_EN
      prev_d    = prev_q;
      delta_d   = delta_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = REQ_LO;
               wait_d  = '0;
            end
         end
         REQ_LO: begin
            // An ack on the last allowed cycle still wins over the abort
            if (bus.ack_i) begin
               lo_d    = bus.count_i;
               state_d = GAP;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         GAP: begin
            // One idle cycle forces req low between the two beats
            state_d = REQ_HI;
            wait_d  = '0;
         end
         REQ_HI: begin
            if (bus.ack_i) begin
               hi_d    = bus.count_i;
               state_d = DONE;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         DONE: begin
            value_d = {hi_q, lo_q};
            valid_d = 1'b1;
`ifdef ACR_DELTA_EN
            delta_d = {hi_q, lo_q} - prev_q;
            prev_d  = {hi_q, lo_q};
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_d    = (state_d == REQ_LO) || (state_d == REQ_HI);
      atomic_d = (state_d == REQ_LO);
   end

   // State and registered outputs; synchronous reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         value_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         req_q     <= 1'b0;
         atomic_q  <= 1'b0;
`ifdef ACR_DELTA_EN
         prev_q    <= '0;
         delta_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         req_q     <= req_d;
         atomic_q  <= atomic_d;
`ifdef ACR_DELTA_EN
         prev_q    <= prev_d;
         delta_q   <= delta_d;
`endif
      end
   end

   assign bus.req_o    = req_q;
   assign bus.atomic_o = atomic_q;
   assign busy_o       = (state_q != IDLE);
   assign valid_o      = valid_q;
   assign value_o      = value_q;
   assign timeout_o    = timeout_q;
`ifdef ACR_DELTA_EN
   assign delta_o      = delta_q;
`endif

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Directed bench for atomic_counter_reader.
// Each scenario is planned up front as a cycle timeline that holds the stimulus and the expected outputs.
// A single loop applies the stimulus and compares every output on every cycle, with a few literal spot checks.
module tb_atomic_counter_reader;

   localparam int W = 32;
   localparam int T = 16;
   localparam int N = 102;

   logic          clk;
   logic          reset;
   logic          start_i;
   logic          busy_o;
   logic          valid_o;
   logic [2*W-1:0] value_o;
   logic          timeout_o;
`ifdef ACR_DELTA_EN
   logic [2*W-1:0] delta_o;
`endif

   atomic_counter_reader_if #(.COUNT_W(W)) bus ();

   atomic_counter_reader #(.COUNT_W(W), .TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start_i),
      .bus       (bus),
      .busy_o    (busy_o),
      .valid_o   (valid_o),
      .value_o   (value_o),
      .timeout_o (timeout_o)
`ifdef ACR_DELTA_EN
      ,
      .delta_o   (delta_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stimulus timeline: the values applied during cycle c are sampled at the edge that ends cycle c
   bit          stim_reset [N];
   bit          stim_start [N];
   bit          stim_ack   [N];
   logic [W-1:0] stim_count [N];

   // Expected outputs during cycle c
   bit           exp_req     [N];
   bit           exp_atomic  [N];
   bit           exp_busy    [N];
   bit           exp_valid   [N];
   bit           exp_timeout [N];
   logic [2*W-1:0] exp_newval [N];
   logic [2*W-1:0] exp_value  [N];
   logic [2*W-1:0] exp_delta  [N];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, expv);
      end
   endtask

   task automatic mark(input int c, input bit r, input bit a, input int cut);
      if (c < cut && c < N) begin
         exp_req[c]    = r;
         exp_atomic[c] = a;
         exp_busy[c]   = 1'b1;
      end
   endtask

   task automatic put_ack(input int c, input logic [W-1:0] d, input int cut);
      if (c < cut && c < N) begin
         stim_ack[c]   = 1'b1;
         stim_count[c] = d;
      end
   endtask

   task automatic put_timeout(input int c, input int cut);
      if (c < cut && c < N) exp_timeout[c] = 1'b1;
   endtask

   // One snapshot read started by a start pulse in cycle s.
   // dl and dh are the ack delays for the two beats, and -1 means no ack, so the beat times out.
   // Outputs from cycle cut onward are left at their reset values.
   task automatic plan_read(input int s, input int dl, input int dh,
                            input logic [W-1:0] lo, input logic [W-1:0] hi, input int cut);
      int len;
      int g;
      int h0;
      int d;
      stim_start[s] = 1'b1;
      len = (dl >= 0) ? dl + 1 : T;
      for (int c = s + 1; c < s + 1 + len; c++) mark(c, 1'b1, 1'b1, cut);
      if (dl < 0) begin
         put_timeout(s + 1 + len, cut);
         return;
      end
      put_ack(s + 1 + dl, lo, cut);
      g = s + 1 + len;
      mark(g, 1'b0, 1'b0, cut);
      h0 = g + 1;
      len = (dh >= 0) ? dh + 1 : T;
      for (int c = h0; c < h0 + len; c++) mark(c, 1'b1, 1'b0, cut);
      if (dh < 0) begin
         put_timeout(h0 + len, cut);
         return;
      end
      put_ack(h0 + dh, hi, cut);
      d = h0 + len;
      mark(d, 1'b0, 1'b0, cut);
      if (d + 1 < cut && d + 1 < N) begin
         exp_valid[d + 1]  = 1'b1;
         exp_newval[d + 1] = {hi, lo};
      end
   endtask

   initial begin
      logic [2*W-1:0] cur;
      logic [2*W-1:0] prev;
      logic [2*W-1:0] dlt;

      for (int c = 0; c < N; c++) begin
         stim_reset[c] = 1'b0;  stim_start[c] = 1'b0;
         stim_ack[c]   = 1'b0;  stim_count[c] = '0;
         exp_req[c]    = 1'b0;  exp_atomic[c] = 1'b0;
         exp_busy[c]   = 1'b0;  exp_valid[c]  = 1'b0;
         exp_timeout[c] = 1'b0; exp_newval[c] = '0;
         exp_value[c]  = '0;    exp_delta[c]  = '0;
      end

      stim_reset[0] = 1'b1;
      stim_reset[1] = 1'b1;
      // Basic read with an immediate ack on both beats
      plan_read(4, 0, 0, 32'h0000_0010, 32'h0000_0002, N);
      // Spurious ack while idle
      stim_ack[11] = 1'b1; stim_count[11] = 32'hDEAD_BEEF;
      // Both beats acked 3 cycles late
      plan_read(12, 3, 3, 32'hAAAA_5555, 32'h1234_5678, N);
      // High beat never acked
      plan_read(26, 0, -1, 32'h0BAD_0BAD, 32'h0, N);
      // start_i held high across a whole read, with a spurious ack in the gap cycle
      plan_read(48, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, N);
      for (int c = 48; c <= 53; c++) stim_start[c] = 1'b1;
      stim_ack[50] = 1'b1; stim_count[50] = 32'h5A5A_5A5A;
      plan_read(53, 0, 0, 32'h0000_0003, 32'h0000_0000, N);
      // Reset asserted while the high beat is outstanding
      plan_read(62, 0, -1, 32'h0000_0099, 32'h0, 67);
      stim_reset[66] = 1'b1;
      // First read after the reset
      plan_read(70, 0, 0, 32'h0000_0007, 32'h0000_0001, N);
      // Ack on the last cycle before the timeout
      plan_read(78, T - 1, 0, 32'h0000_0011, 32'h0000_0022, N);

      // Held value and delta: a reset clears both, and each valid pulse loads a new snapshot
      cur = '0; prev = '0; dlt = '0;
      for (int c = 1; c < N; c++) begin
         if (stim_reset[c-1]) begin
            cur = '0; prev = '0; dlt = '0;
         end else if (exp_valid[c]) begin
            dlt  = exp_newval[c] - prev;
            prev = exp_newval[c];
            cur  = exp_newval[c];
         end
         exp_value[c] = cur;
         exp_delta[c] = dlt;
      end

      reset = stim_reset[0]; start_i = stim_start[0];
      bus.ack_i = stim_ack[0]; bus.count_i = stim_count[0];
      for (int c = 1; c < N; c++) begin
         @(posedge clk);
         #1;
         reset = stim_reset[c]; start_i = stim_start[c];
         bus.ack_i = stim_ack[c]; bus.count_i = stim_count[c];
         chk("req",     c, 64'(bus.req_o),    64'(exp_req[c]));
         chk("atomic",  c, 64'(bus.atomic_o), 64'(exp_atomic[c]));
         chk("busy",    c, 64'(busy_o),       64'(exp_busy[c]));
         chk("valid",   c, 64'(valid_o),      64'(exp_valid[c]));
         chk("timeout", c, 64'(timeout_o),    64'(exp_timeout[c]));
         chk("value",   c, value_o,           exp_value[c]);
`ifdef ACR_DELTA_EN
         chk("delta",   c, delta_o,           exp_delta[c]);
`endif
         case (c)
            2:  chk("lit_reset_value", c, value_o, 64'h0);
            5:  chk("lit_beat1_atomic", c, 64'(bus.atomic_o), 64'h1);
            6:  chk("lit_gap_req", c, 64'(bus.req_o), 64'h0);
            7:  chk("lit_beat2_atomic", c, 64'(bus.atomic_o), 64'h0);
            9:  chk("lit_basic_value", c, value_o, 64'h0000_0002_0000_0010);
            22: chk("lit_delay_busy", c, 64'(busy_o), 64'h1);
            23: chk("lit_delay_valid", c, 64'(valid_o), 64'h1);
            45: chk("lit_timeout", c, 64'(timeout_o), 64'h1);
            46: chk("lit_timeout_keep", c, value_o, 64'h1234_5678_AAAA_5555);
            53: chk("lit_held_value", c, value_o, 64'hFFFF_FFFF_FFFF_FFFE);
            58: chk("lit_second_value", c, value_o, 64'h0000_0000_0000_0003);
            67: chk("lit_reset_req", c, 64'(bus.req_o), 64'h0);
            68: chk("lit_reset_clear", c, value_o, 64'h0);
            98: chk("lit_late_ack", c, value_o, 64'h0000_0022_0000_0011);
            default: ;
         endcase
`ifdef ACR_DELTA_EN
         if (c == 58) chk("lit_delta_wrap", c, delta_o, 64'h5);
         if (c == 75) chk("lit_delta_first", c, delta_o, 64'h0000_0001_0000_0007);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/atomic_counter_reader.md
Name: atomic_counter_reader

Overview:
- Initiator for the atomic counter's req/atomic/ack read interface; drives req/atomic and consumes ack/count.
- On a single start pulse it performs a two-beat snapshot read of the 64-bit counter. Beat 1 is an atomic read that returns the low word and freezes the high word. Beat 2 is a plain read that returns the frozen high word.
- Delivers the assembled 64-bit value to a local consumer with a one-cycle valid pulse. Sits between the counter and software-visible status logic.

Parameters:
- COUNT_W, 32, width of count_i / one counter beat
- TIMEOUT_CYCLES, 16, max cycles a beat may wait for ack_i before abort (≥2)

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  synchronous reset, active-high
- start_i  input  1  begin a snapshot read; sampled only in IDLE
- req_o  output  1  request to counter, held until ack_i or timeout
- atomic_o  output  1  1 = atomic (low-word, freeze high) beat; 0 = plain beat
- ack_i  input  1  single-cycle acknowledge from counter; count_i valid same cycle
- count_i  input  COUNT_W  counter data beat
- busy_o  output  1  high in any state except IDLE
- valid_o  output  1  one-cycle pulse, value_o valid
- value_o  output  2*COUNT_W  {high word, low word}; holds last good snapshot
- timeout_o  output  1  one-cycle pulse on beat abort

Behaviour:
- Reset, synchronous and active-high, dominates all other inputs. Outputs after reset: req_o=0, atomic_o=0, busy_o=0, valid_o=0, timeout_o=0, value_o=0, state=IDLE, wait counter=0.
- States and transitions:
  - IDLE: if start_i=1, go to REQ_LO.
  - REQ_LO: req_o=1, atomic_o=1.
    - ack_i=1: capture count_i into lo register, go to GAP.
    - Otherwise, after the wait counter reaches TIMEOUT_CYCLES-1: go to IDLE with timeout_o pulse.
  - GAP: req_o=0, atomic_o=0 for exactly one cycle, then go to REQ_HI. This guarantees a req deassertion between beats.
  - REQ_HI: req_o=1, atomic_o=0.
    - ack_i=1: capture count_i into hi register, go to DONE.
    - Timeout is handled as in REQ_LO.
  - DONE: value_o <= {hi, lo}, valid_o=1 for this single cycle, then go to IDLE.
- Outputs req_o and atomic_o are registered, decoded from state. Earliest req_o is the cycle after start_i is sampled.
- Wait counter clears on entry to REQ_LO and REQ_HI and increments each cycle without ack.
- Minimum latency with ack_i returned on the first req cycle: start_i at cycle 0 → valid_o at cycle 5 (REQ_LO@1, GAP@2, REQ_HI@3, DONE@4, value_o and valid_o visible @5).
- ack_i is ignored in IDLE, GAP and DONE; it causes no capture and no error.
- start_i is ignored while busy_o=1; there is no queueing.
- A timeout leaves value_o unchanged. Partial lo data is discarded.
- Ack on the timeout cycle: ack wins, capture proceeds, no timeout_o.
- Reset mid-transaction: req_o drops the next edge; no valid_o or timeout_o is emitted.
- No arithmetic on data; width is exactly 2*COUNT_W with no truncation.

Optional Feature:
- Macro: ACR_DELTA_EN.
- Defined:
  - Adds output delta_o [2*COUNT_W-1:0] and an internal prev register.
  - In DONE: delta_o <= {hi,lo} - prev, modulo 2^(2*COUNT_W), so wrap-around yields the correct small delta. Then prev <= {hi,lo}.
  - First snapshot after reset: delta_o equals the value itself, since prev resets to 0.
  - delta_o resets to 0 and updates only with valid_o.
- Undefined: no delta_o port, no prev register; behaviour otherwise identical.

Test Plan:
- Basic read: reset, start_i pulse, responder acks immediately with lo=0x0000_0010, hi=0x0000_0002 → atomic_o=1 on beat 1 and 0 on beat 2; req_o low for one cycle between beats; valid_o pulse 5 cycles after start; value_o=0x0000_0002_0000_0010.
- Delayed ack: ack_i delayed 3 cycles on each beat → req_o held steady through the wait; valid_o at cycle 11; busy_o high for cycles 1–10.
- Timeout: no ack on beat 2 with TIMEOUT_CYCLES=16 → timeout_o pulse, return to IDLE; value_o keeps its previous value; valid_o stays 0.
- Ignored inputs: start_i held high through a whole transaction → exactly one read pair before returning to IDLE, then a new read starts. A spurious ack_i in GAP → no capture.
- Reset mid-op: reset asserted in REQ_HI → req_o=0 the next cycle; value_o=0; no valid_o.
- ACR_DELTA_EN wrap: first read 0xFFFF_FFFF_FFFF_FFFE, second read 0x0000_0000_0000_0003 → delta_o=0x5 on the second valid_o.
